// File: rtl/reg_10bits_serializer.sv
// Parallel-in / serial-out shifter: loads a word on a valid/ready handshake, emits one bit per consumer handshake.
// Latency: word accepted at edge N, first bit valid in cycle N+1, last bit in N+10, ready again in N+11.
// Backpressure: ser_ready low freezes sreg, cnt and all outputs; load_ready is low for the whole word.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - asynchronous active-low reset
//   d          - parallel word, sampled only on the accepting edge
//   load_valid - producer presents d
//   load_ready - block can accept a word (high only in IDLE)
//   ser_out    - current serial bit (0 in IDLE)
//   ser_valid  - ser_out holds a valid bit
//   ser_ready  - consumer takes ser_out this cycle
//   ser_last   - current bit is the final bit of the word
//   busy       - a word is in flight
module reg_10bits_serializer #(
    parameter int WIDTH     = 10,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy
);

    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sreg_q;
    logic [CW-1:0]    cnt_q;

    logic in_shift;
    logic at_last;

    assign in_shift = (state_q == SHIFT);
    assign at_last  = (cnt_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // load_ready is constantly 1 here, so load_valid alone completes the handshake.
                    // ser_ready is irrelevant: nothing is being offered yet.
                    if (load_valid) begin
                        state_q <= SHIFT;
                        sreg_q  <= d;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    // ser_valid is constantly 1 here; load_valid is ignored.
                    if (ser_ready) begin
                        if (at_last) begin
                            // Clearing sreg keeps ser_out at 0 in IDLE and leaves no residue.
                            state_q <= IDLE;
                            sreg_q  <= '0;
                            cnt_q   <= '0;
                        end else begin
                            if (MSB_FIRST) begin
                                sreg_q <= {sreg_q[WIDTH-2:0], 1'b0};
                            end else begin
                                sreg_q <= {1'b0, sreg_q[WIDTH-1:1]};
                            end
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    sreg_q  <= '0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Pure decode of registered state: no input reaches any output combinationally.
    assign load_ready = !in_shift;
    assign ser_valid  = in_shift;
    assign busy       = in_shift;
    assign ser_out    = in_shift & (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);
    assign ser_last   = in_shift & at_last;

endmodule

// File: tb/tb_reg_10bits_serializer.sv
module tb_reg_10bits_serializer;

    logic       clk;
    logic       rst;
    logic [9:0] d;
    logic       load_valid;
    logic       ser_ready;

    logic m_load_ready, m_ser_out, m_ser_valid, m_ser_last, m_busy;
    logic l_load_ready, l_ser_out, l_ser_valid, l_ser_last, l_busy;

    int checks;
    int errors;

    reg_10bits_serializer #(.WIDTH(10), .MSB_FIRST(1'b1)) dut_m (
        .clk        (clk),
        .rst        (rst),
        .d          (d),
        .load_valid (load_valid),
        .load_ready (m_load_ready),
        .ser_out    (m_ser_out),
        .ser_valid  (m_ser_valid),
        .ser_ready  (ser_ready),
        .ser_last   (m_ser_last),
        .busy       (m_busy)
    );

    reg_10bits_serializer #(.WIDTH(10), .MSB_FIRST(1'b0)) dut_l (
        .clk        (clk),
        .rst        (rst),
        .d          (d),
        .load_valid (load_valid),
        .load_ready (l_load_ready),
        .ser_out    (l_ser_out),
        .ser_valid  (l_ser_valid),
        .ser_ready  (ser_ready),
        .ser_last   (l_ser_last),
        .busy       (l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word and complete the load handshake; returns in cycle N+1.
    task automatic load_word(input logic [9:0] w);
        d          = w;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        d          = 10'h3C3;  // scramble d after acceptance
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        d          = 10'h3FF;
        load_valid = 1'b1;
        ser_ready  = 1'b1;
        #1;
        checks++;
        if ({m_load_ready, m_ser_valid, m_ser_out, m_ser_last, m_busy} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 10000",
                     {m_load_ready, m_ser_valid, m_ser_out, m_ser_last, m_busy});
        end
        tick();
        tick();
        checks++;
        if ({m_busy, l_busy, m_ser_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ignores_load: got busy_m/busy_l/valid %b expected 000",
                     {m_busy, l_busy, m_ser_valid});
        end
        load_valid = 1'b0;
        rst        = 1'b1;
        tick();
    endtask

    task automatic test_msb_first();
        logic [0:9] exp;
        exp       = 10'b1011001110;
        ser_ready = 1'b1;  // also asserted during the load cycle: only the load may act
        checks++;
        if (m_load_ready !== 1'b1) begin
            errors++;
            $display("FAIL msb_load_ready: got %b expected 1", m_load_ready);
        end
        load_word(10'b1011001110);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({m_ser_valid, m_ser_out, m_ser_last} !== {1'b1, exp[i], 1'(i == 9)}) begin
                errors++;
                $display("FAIL msb_bit[%0d]: got valid/out/last %b expected %b", i,
                         {m_ser_valid, m_ser_out, m_ser_last}, {1'b1, exp[i], 1'(i == 9)});
            end
            tick();
        end
        checks++;
        if ({m_load_ready, m_ser_valid, m_busy, m_ser_out} !== 4'b1000) begin
            errors++;
            $display("FAIL msb_idle_after: got ready/valid/busy/out %b expected 1000",
                     {m_load_ready, m_ser_valid, m_busy, m_ser_out});
        end
        tick();
    endtask

    task automatic test_lsb_first();
        logic [0:9] exp;
        exp       = 10'b1010010101;
        ser_ready = 1'b1;
        load_word(10'h2A5);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({l_ser_valid, l_ser_out, l_ser_last} !== {1'b1, exp[i], 1'(i == 9)}) begin
                errors++;
                $display("FAIL lsb_bit[%0d]: got valid/out/last %b expected %b", i,
                         {l_ser_valid, l_ser_out, l_ser_last}, {1'b1, exp[i], 1'(i == 9)});
            end
            tick();
        end
        checks++;
        if ({l_load_ready, l_ser_valid, l_busy} !== 3'b100) begin
            errors++;
            $display("FAIL lsb_idle_after: got ready/valid/busy %b expected 100",
                     {l_load_ready, l_ser_valid, l_busy});
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [3:0] pat;
        int         hs;
        pat       = 4'b1001;  // ser_ready sequence 1,0,0,1 (pat[3] first)
        hs        = 0;
        ser_ready = 1'b0;
        load_word(10'h3FF);
        for (int c = 0; c < 60; c++) begin
            if (hs >= 10) break;
            checks++;
            if ({m_busy, m_ser_valid, m_ser_out, m_ser_last} !== {3'b111, 1'(hs == 9)}) begin
                errors++;
                $display("FAIL bp_cycle[%0d]: got busy/valid/out/last %b expected %b", c,
                         {m_busy, m_ser_valid, m_ser_out, m_ser_last}, {3'b111, 1'(hs == 9)});
            end
            ser_ready = pat[3 - (c % 4)];
            if (ser_ready) hs++;
            tick();
        end
        ser_ready = 1'b1;
        checks++;
        if (hs != 10 || m_busy !== 1'b0 || l_busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_handshakes: got %0d handshakes busy_m=%b busy_l=%b expected 10,0,0",
                     hs, m_busy, l_busy);
        end
        tick();
    endtask

    task automatic test_load_while_busy();
        logic [0:9] exp_a;
        logic [0:9] exp_b;
        exp_a     = 10'b1010100101;  // 10'h2A5 MSB first
        exp_b     = 10'b0101010101;  // 10'h155 MSB first
        ser_ready = 1'b1;
        load_word(10'h2A5);
        d          = 10'h155;
        load_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({m_load_ready, m_ser_out, m_ser_last} !== {1'b0, exp_a[i], 1'(i == 9)}) begin
                errors++;
                $display("FAIL busy_word_a[%0d]: got ready/out/last %b expected %b", i,
                         {m_load_ready, m_ser_out, m_ser_last}, {1'b0, exp_a[i], 1'(i == 9)});
            end
            tick();
        end
        checks++;
        if (m_load_ready !== 1'b1 || m_ser_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_gap: got ready/valid %b%b expected 10", m_load_ready, m_ser_valid);
        end
        tick();  // held load_valid is accepted here
        load_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({m_ser_valid, m_ser_out, m_ser_last} !== {1'b1, exp_b[i], 1'(i == 9)}) begin
                errors++;
                $display("FAIL busy_word_b[%0d]: got valid/out/last %b expected %b", i,
                         {m_ser_valid, m_ser_out, m_ser_last}, {1'b1, exp_b[i], 1'(i == 9)});
            end
            tick();
        end
        tick();
    endtask

    task automatic test_abort();
        logic [0:9] exp_a;
        logic [0:9] exp_b;
        exp_a     = 10'b0011110000;  // 10'h0F0 MSB first
        exp_b     = 10'b0000000001;  // 10'h001 MSB first
        ser_ready = 1'b1;
        load_word(10'h0F0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (m_ser_out !== exp_a[i]) begin
                errors++;
                $display("FAIL abort_pre_bit[%0d]: got %b expected %b", i, m_ser_out, exp_a[i]);
            end
            tick();
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({m_load_ready, m_ser_valid, m_ser_out, m_ser_last, m_busy} !== 5'b10000) begin
            errors++;
            $display("FAIL abort_async: got %b expected 10000",
                     {m_load_ready, m_ser_valid, m_ser_out, m_ser_last, m_busy});
        end
        d          = 10'h3FF;
        load_valid = 1'b1;
        tick();
        tick();
        load_valid = 1'b0;
        rst        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (m_ser_valid !== 1'b0 || m_busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet[%0d]: got valid/busy %b%b expected 00", i,
                         m_ser_valid, m_busy);
            end
        end
        load_word(10'h001);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({m_ser_valid, m_ser_out, m_ser_last} !== {1'b1, exp_b[i], 1'(i == 9)}) begin
                errors++;
                $display("FAIL abort_new_word[%0d]: got valid/out/last %b expected %b", i,
                         {m_ser_valid, m_ser_out, m_ser_last}, {1'b1, exp_b[i], 1'(i == 9)});
            end
            tick();
        end
        checks++;
        if (m_ser_valid !== 1'b0 || m_load_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_end: got valid/ready %b%b expected 01", m_ser_valid, m_load_ready);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_backpressure();
        test_load_while_busy();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
